// File: rtl/collision_detect.sv
// Bird/pipe pixel-overlap detector: glitch filter, grace period, vblank-aligned pulse.
// Optional ground band hit when COLLISION_GROUND_EN is defined.
module collision_detect #(
    parameter int unsigned MIN_OVERLAP  = 4,
    parameter int unsigned GRACE_FRAMES = 30,
    parameter int unsigned GROUND_Y     = 560
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_game_rst,
    input  logic [10:0] i_hcount,
    input  logic [10:0] i_vcount,
    input  logic        i_vblnk,
    input  logic        i_bird_px,
    input  logic        i_pipe_px,
    output logic        o_collision,
    output logic        o_armed,
    output logic [10:0] o_hit_x,
    output logic [10:0] o_hit_y
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRACE = 2'd1,
        S_ARMED = 2'd2,
        S_HIT   = 2'd3
    } state_t;

    localparam logic [3:0]  LP_MIN      = 4'(MIN_OVERLAP);
    localparam logic [7:0]  LP_GRACE    = 8'(GRACE_FRAMES);
    localparam logic [10:0] LP_GROUND_Y = 11'(GROUND_Y);

`ifdef COLLISION_GROUND_EN
    localparam bit LP_GROUND_EN = 1'b1;
`else
    localparam bit LP_GROUND_EN = 1'b0;
`endif

    state_t      r_state;
    logic        r_vblnk_q;
    logic [3:0]  r_run;
    logic [7:0]  r_grace;
    logic        r_hit_flag;
    logic        r_collision;
    logic        r_armed;
    logic [10:0] r_hit_x;
    logic [10:0] r_hit_y;

    logic        w_fe;
    logic        w_ov;
    logic        w_line_start;
    logic [3:0]  w_run_nxt;
    logic        w_run_hit;
    logic        w_ground;

    assign w_fe         = i_vblnk & ~r_vblnk_q;
    assign w_ov         = i_bird_px & i_pipe_px & ~i_vblnk;
    assign w_line_start = (i_hcount == 11'd0);

    // Run restarts on any gap and at the left edge of every line.
    always_comb begin
        w_run_nxt = 4'd0;
        if (w_ov && !w_line_start) begin
            w_run_nxt = (r_run == LP_MIN) ? r_run : r_run + 4'd1;
        end
    end

    assign w_run_hit = w_ov && !w_line_start
                    && (r_run != LP_MIN)
                    && ((r_run + 4'd1) == LP_MIN);

    assign w_ground = LP_GROUND_EN & i_bird_px & ~i_vblnk
                    & (i_vcount >= LP_GROUND_Y);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_vblnk_q   <= 1'b0;
            r_run       <= 4'd0;
            r_grace     <= 8'd0;
            r_hit_flag  <= 1'b0;
            r_collision <= 1'b0;
            r_armed     <= 1'b0;
            r_hit_x     <= 11'd0;
            r_hit_y     <= 11'd0;
        end else begin
            r_vblnk_q   <= i_vblnk;
            r_collision <= 1'b0;
            if (i_game_rst) begin
                r_state    <= S_GRACE;
                r_armed    <= 1'b0;
                r_grace    <= 8'd0;
                r_run      <= 4'd0;
                r_hit_flag <= 1'b0;
                r_hit_x    <= 11'd0;
                r_hit_y    <= 11'd0;
            end else if (!i_enable) begin
                r_state    <= S_IDLE;
                r_armed    <= 1'b0;
                r_grace    <= 8'd0;
                r_run      <= 4'd0;
                r_hit_flag <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_GRACE;
                        r_grace <= 8'd0;
                    end
                    S_GRACE: begin
                        if (r_grace == LP_GRACE) begin
                            r_state    <= S_ARMED;
                            r_armed    <= 1'b1;
                            r_run      <= 4'd0;
                            r_hit_flag <= 1'b0;
                        end else if (w_fe && (r_grace != 8'hFF)) begin
                            r_grace <= r_grace + 8'd1;
                        end
                    end
                    S_ARMED: begin
                        r_run <= w_run_nxt;
                        if (w_fe) begin
                            r_hit_flag <= 1'b0;
                            if (r_hit_flag) begin
                                r_collision <= 1'b1;
                                r_state     <= S_HIT;
                                r_armed     <= 1'b0;
                            end
                        end else if (!r_hit_flag && (w_run_hit || w_ground)) begin
                            r_hit_flag <= 1'b1;
                            if (w_run_hit) begin
                                r_hit_x <= i_hcount;
                                r_hit_y <= i_vcount;
                            end
                        end
                    end
                    S_HIT: begin
                        r_run      <= 4'd0;
                        r_hit_flag <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_collision = r_collision;
    assign o_armed     = r_armed;
    assign o_hit_x     = r_hit_x;
    assign o_hit_y     = r_hit_y;

endmodule

// File: tb/tb_collision_detect.sv
// Self-checking bench for collision_detect using a compressed pixel/frame stream.
// Expected pulses go to a scoreboard queue and are matched when o_collision fires.
module tb_collision_detect;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_game_rst = 1'b0;
    logic [10:0] i_hcount = 11'd0;
    logic [10:0] i_vcount = 11'd0;
    logic        i_vblnk = 1'b0;
    logic        i_bird_px = 1'b0;
    logic        i_pipe_px = 1'b0;
    logic        o_collision;
    logic        o_armed;
    logic [10:0] o_hit_x;
    logic [10:0] o_hit_y;

    always #5 clk = ~clk;

    collision_detect dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_game_rst  (i_game_rst),
        .i_hcount    (i_hcount),
        .i_vcount    (i_vcount),
        .i_vblnk     (i_vblnk),
        .i_bird_px   (i_bird_px),
        .i_pipe_px   (i_pipe_px),
        .o_collision (o_collision),
        .o_armed     (o_armed),
        .o_hit_x     (o_hit_x),
        .o_hit_y     (o_hit_y)
    );

    typedef struct {
        int          cyc;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Pulse monitor: every pulse must match the oldest scoreboard entry.
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (o_collision) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: collision=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || o_hit_x !== e.x || o_hit_y !== e.y) begin
                    n_fail++;
                    $display("FAIL pulse_match: cyc=%0d x=%0d y=%0d, required cyc=%0d x=%0d y=%0d",
                             cyc, o_hit_x, o_hit_y, e.cyc, e.x, e.y);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v,
                       input logic b, input logic p);
        step();
        i_hcount  = h;
        i_vcount  = v;
        i_bird_px = b;
        i_pipe_px = p;
        i_vblnk   = 1'b0;
    endtask

    task automatic run_ov(input logic [10:0] h0, input logic [10:0] v, input int n);
        for (int k = 0; k < n; k++) pix(h0 + 11'(k), v, 1'b1, 1'b1);
        pix(h0 + 11'(n), v, 1'b0, 1'b0);
    endtask

    task automatic frame_end(input bit ex, input logic [10:0] ex_x, input logic [10:0] ex_y);
        exp_t e;
        step();
        i_bird_px = 1'b0;
        i_pipe_px = 1'b0;
        i_vblnk   = 1'b1;
        if (ex) begin
            e.cyc = cyc + 1;
            e.x   = ex_x;
            e.y   = ex_y;
            sb.push_back(e);
        end
        step();
        step();
        step();
        i_vblnk = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) frame_end(1'b0, 11'd0, 11'd0);
    endtask

    task automatic pulse_game_rst();
        step();
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_enable = 1'b0;
        step();
        step();
        n_chk++;
        if (o_collision !== 1'b0) begin
            n_fail++; $display("FAIL rst_collision: got %b, required 0", o_collision);
        end
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL rst_armed: got %b, required 0", o_armed);
        end
        n_chk++;
        if (o_hit_x !== 11'd0) begin
            n_fail++; $display("FAIL rst_hit_x: got %0d, required 0", o_hit_x);
        end
        n_chk++;
        if (o_hit_y !== 11'd0) begin
            n_fail++; $display("FAIL rst_hit_y: got %0d, required 0", o_hit_y);
        end
        i_rst = 1'b0;
        i_enable = 1'b1;
        step();
        step();
        frames(29);
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL grace_29: armed=%b, required 0", o_armed);
        end
        frames(1);
        n_chk++;
        if (o_armed !== 1'b1) begin
            n_fail++; $display("FAIL grace_30: armed=%b, required 1", o_armed);
        end
    endtask

    task automatic test_gap();
        run_ov(11'd100, 11'd200, 3);
        run_ov(11'd105, 11'd200, 3);
        pix(11'd14, 11'd201, 1'b1, 1'b1);
        pix(11'd15, 11'd201, 1'b1, 1'b1);
        pix(11'd0,  11'd202, 1'b1, 1'b1);
        pix(11'd1,  11'd202, 1'b1, 1'b1);
        pix(11'd2,  11'd202, 1'b0, 1'b0);
        frame_end(1'b0, 11'd0, 11'd0);
        n_chk++;
        if (o_armed !== 1'b1) begin
            n_fail++; $display("FAIL gap_armed: armed=%b, required 1", o_armed);
        end
        n_chk++;
        if (o_hit_x !== 11'd0) begin
            n_fail++; $display("FAIL gap_hit_x: got %0d, required 0", o_hit_x);
        end
    endtask

    task automatic test_hit();
        run_ov(11'd200, 11'd300, 4);
        n_chk++;
        if (o_hit_x !== 11'd203) begin
            n_fail++; $display("FAIL hit_x: got %0d, required 203", o_hit_x);
        end
        n_chk++;
        if (o_hit_y !== 11'd300) begin
            n_fail++; $display("FAIL hit_y: got %0d, required 300", o_hit_y);
        end
        frame_end(1'b1, 11'd203, 11'd300);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL hit_pulse_missing: pending=%0d, required 0", sb.size());
        end
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL hit_armed: armed=%b, required 0", o_armed);
        end
    endtask

    task automatic test_hit_hold();
        for (int f = 0; f < 5; f++) begin
            run_ov(11'd50 + 11'(f), 11'd120, 10);
            frame_end(1'b0, 11'd0, 11'd0);
        end
        n_chk++;
        if (o_hit_x !== 11'd203 || o_hit_y !== 11'd300) begin
            n_fail++; $display("FAIL hold_xy: got %0d,%0d, required 203,300", o_hit_x, o_hit_y);
        end
        pulse_game_rst();
        n_chk++;
        if (o_hit_x !== 11'd0 || o_hit_y !== 11'd0) begin
            n_fail++; $display("FAIL grst_xy: got %0d,%0d, required 0,0", o_hit_x, o_hit_y);
        end
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL grst_armed: armed=%b, required 0", o_armed);
        end
    endtask

    task automatic test_grace();
        frames(10);
        run_ov(11'd50, 11'd100, 20);
        frame_end(1'b0, 11'd0, 11'd0);
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL grace_mid_armed: armed=%b, required 0", o_armed);
        end
        frames(19);
        n_chk++;
        if (o_armed !== 1'b1) begin
            n_fail++; $display("FAIL grace_end_armed: armed=%b, required 1", o_armed);
        end
        run_ov(11'd50, 11'd100, 20);
        n_chk++;
        if (o_hit_x !== 11'd53) begin
            n_fail++; $display("FAIL grace_hit_x: got %0d, required 53", o_hit_x);
        end
        frame_end(1'b1, 11'd53, 11'd100);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL grace_pulse_missing: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_rst_on_fe();
        pulse_game_rst();
        frames(30);
        run_ov(11'd60, 11'd400, 5);
        n_chk++;
        if (o_hit_x !== 11'd63) begin
            n_fail++; $display("FAIL fe_rst_pre_x: got %0d, required 63", o_hit_x);
        end
        step();
        i_vblnk = 1'b1;
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        n_chk++;
        if (o_armed !== 1'b0 || o_hit_x !== 11'd0) begin
            n_fail++; $display("FAIL fe_rst_state: armed=%b x=%0d, required 0 0", o_armed, o_hit_x);
        end
        step();
        step();
        i_vblnk = 1'b0;
        step();
    endtask

    task automatic test_ground();
        frames(30);
        n_chk++;
        if (o_armed !== 1'b1) begin
            n_fail++; $display("FAIL ground_armed: armed=%b, required 1", o_armed);
        end
        pix(11'd10, 11'd559, 1'b1, 1'b0);
        pix(11'd11, 11'd559, 1'b0, 1'b0);
        frame_end(1'b0, 11'd0, 11'd0);
        pix(11'd10, 11'd560, 1'b1, 1'b0);
        pix(11'd11, 11'd560, 1'b0, 1'b0);
`ifdef COLLISION_GROUND_EN
        frame_end(1'b1, 11'd0, 11'd0);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL ground_pulse_missing: pending=%0d, required 0", sb.size());
        end
`else
        frame_end(1'b0, 11'd0, 11'd0);
        n_chk++;
        if (o_armed !== 1'b1) begin
            n_fail++; $display("FAIL ground_ignored: armed=%b, required 1", o_armed);
        end
`endif
    endtask

    task automatic test_disable();
        pulse_game_rst();
        frames(30);
        step();
        i_enable = 1'b0;
        step();
        n_chk++;
        if (o_armed !== 1'b0) begin
            n_fail++; $display("FAIL disable_armed: armed=%b, required 0", o_armed);
        end
        run_ov(11'd80, 11'd90, 8);
        frame_end(1'b0, 11'd0, 11'd0);
    endtask

    initial begin
        test_reset();
        test_gap();
        test_hit();
        test_hit_hold();
        test_grace();
        test_rst_on_fe();
        test_ground();
        test_disable();
        step();
        step();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL final_scoreboard: pending=%0d, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
